// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a shared combinational ALU.
// One operation in flight at a time: accept (IDLE) -> capture (EXEC) -> deliver (RESP).
module alu_arbiter #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [3:0]        req0_sel,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,

    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [3:0]        req1_sel,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,

    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic [DATA_W-1:0] rsp0_result,
    output logic [4:0]        rsp0_flags,

    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [DATA_W-1:0] rsp1_result,
    output logic [4:0]        rsp1_flags,

    output logic [3:0]        ALU_SEL,
    output logic [DATA_W-1:0] A,
    output logic [DATA_W-1:0] B,
    input  logic [DATA_W-1:0] ALU_OUT,
    input  logic              carry,
    input  logic              zero,
    input  logic              negative,
    input  logic              overflow,
    input  logic              underflow,

    output logic              busy,
    output logic [CNT_W-1:0]  done0_cnt,
    output logic [CNT_W-1:0]  done1_cnt
);

    typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

    state_e     state_q, state_d;
    logic       pref_q, pref_d;    // requester preferred at the next contested accept
    logic       grant_q, grant_d;  // requester currently being served
    logic       hs0, hs1;
    logic       rsp0_hs, rsp1_hs;
    logic [4:0] alu_flags;

    assign alu_flags  = {carry, zero, negative, overflow, underflow};
    assign busy       = (state_q != StIdle);
    assign rsp0_valid = (state_q == StResp) && !grant_q;
    assign rsp1_valid = (state_q == StResp) && grant_q;
    assign rsp0_hs    = rsp0_valid && rsp0_ready;
    assign rsp1_hs    = rsp1_valid && rsp1_ready;

    always_comb begin
        state_d    = state_q;
        pref_d     = pref_q;
        grant_d    = grant_q;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        hs0        = 1'b0;
        hs1        = 1'b0;
        unique case (state_q)
            StIdle: begin
                // Only the preferred side is ready when both contend, so at most one handshake.
                req0_ready = !pref_q || !req1_valid;
                req1_ready = pref_q || !req0_valid;
                hs0        = req0_valid && req0_ready;
                hs1        = req1_valid && req1_ready;
                if (hs0 || hs1) begin
                    state_d = StExec;
                    grant_d = hs1;
                    pref_d  = !hs1;
                end
            end
            StExec: state_d = StResp;
            StResp: begin
                if (rsp0_hs || rsp1_hs) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            pref_q  <= 1'b0;
            grant_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pref_q  <= pref_d;
            grant_q <= grant_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ALU_SEL <= '0;
            A       <= '0;
            B       <= '0;
        end else if (hs0) begin
            ALU_SEL <= req0_sel;
            A       <= req0_a;
            B       <= req0_b;
        end else if (hs1) begin
            ALU_SEL <= req1_sel;
            A       <= req1_a;
            B       <= req1_b;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp0_result <= '0;
            rsp0_flags  <= '0;
            rsp1_result <= '0;
            rsp1_flags  <= '0;
        end else if (state_q == StExec) begin
            if (!grant_q) begin
                rsp0_result <= ALU_OUT;
                rsp0_flags  <= alu_flags;
            end else begin
                rsp1_result <= ALU_OUT;
                rsp1_flags  <= alu_flags;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done0_cnt <= '0;
            done1_cnt <= '0;
        end else begin
            if (rsp0_hs) begin
                done0_cnt <= done0_cnt + CNT_W'(1);
            end
            if (rsp1_hs) begin
                done1_cnt <= done1_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: a behavioural ALU feeds the DUT, a negedge monitor
// checks arbitration, responses and counters against a queue-based model.
module tb_alu_arbiter;

    localparam int DW = 32;
    localparam int CW = 4;

    typedef struct packed {
        logic [DW-1:0] res;
        logic [4:0]    flg;
    } rsp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req0_valid, req0_ready, req1_valid, req1_ready;
    logic [3:0]    req0_sel, req1_sel, ALU_SEL;
    logic [DW-1:0] req0_a, req0_b, req1_a, req1_b, A, B, ALU_OUT;
    logic          rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
    logic [DW-1:0] rsp0_result, rsp1_result;
    logic [4:0]    rsp0_flags, rsp1_flags;
    logic          carry, zero, negative, overflow, underflow, busy;
    logic [CW-1:0] done0_cnt, done1_cnt;

    alu_arbiter #(.DATA_W(DW), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_sel(req0_sel),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_sel(req1_sel),
        .req1_a(req1_a), .req1_b(req1_b),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result),
        .rsp0_flags(rsp0_flags),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result),
        .rsp1_flags(rsp1_flags),
        .ALU_SEL(ALU_SEL), .A(A), .B(B), .ALU_OUT(ALU_OUT),
        .carry(carry), .zero(zero), .negative(negative), .overflow(overflow),
        .underflow(underflow),
        .busy(busy), .done0_cnt(done0_cnt), .done1_cnt(done1_cnt)
    );

    always #5 clk = ~clk;

    // Environment ALU: 0 add, 1 B-A, 2 and, 3 or, 4 xor, others pass A.
    function automatic rsp_t alu_ref(input logic [3:0] sel, input logic [DW-1:0] a,
                                     input logic [DW-1:0] b);
        rsp_t        r;
        logic [DW:0] w;
        logic        c, ov, un;
        c = 1'b0; ov = 1'b0; un = 1'b0;
        case (sel)
            4'd0: begin
                w     = {1'b0, a} + {1'b0, b};
                r.res = w[DW-1:0];
                c     = w[DW];
                ov    = (a[DW-1] == b[DW-1]) && (r.res[DW-1] != a[DW-1]);
            end
            4'd1: begin
                r.res = b - a;
                un    = (b < a);
                ov    = (a[DW-1] != b[DW-1]) && (r.res[DW-1] != b[DW-1]);
            end
            4'd2:    r.res = a & b;
            4'd3:    r.res = a | b;
            4'd4:    r.res = a ^ b;
            default: r.res = a;
        endcase
        r.flg = {c, (r.res == '0), r.res[DW-1], ov, un};
        return r;
    endfunction

    rsp_t alu_now;
    always_comb alu_now = alu_ref(ALU_SEL, A, B);
    assign ALU_OUT = alu_now.res;
    assign {carry, zero, negative, overflow, underflow} = alu_now.flg;

    int   total = 0;
    int   passed = 0;
    rsp_t q0[$];
    rsp_t q1[$];
    int   glog[$];
    int   mcnt0 = 0;
    int   mcnt1 = 0;
    logic mpref = 1'b0;
    logic outst = 1'b0;
    logic hold0_v = 1'b0;
    logic hold1_v = 1'b0;
    rsp_t hold0, hold1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Monitor: outputs are stable at the falling edge; handshakes seen here land on the next rise.
    always @(negedge clk) begin
        if (!rst_n) begin
            q0.delete(); q1.delete();
            mcnt0 = 0; mcnt1 = 0; mpref = 1'b0; outst = 1'b0;
            hold0_v = 1'b0; hold1_v = 1'b0;
        end else begin
            check("busy", busy, outst);
            check("req0_ready", req0_ready, !outst && (!mpref || !req1_valid));
            check("req1_ready", req1_ready, !outst && (mpref || !req0_valid));
            if (hold0_v) begin
                check("rsp0_valid held", rsp0_valid, 1);
                check("rsp0 stable", {rsp0_result, rsp0_flags}, hold0);
            end
            if (hold1_v) begin
                check("rsp1_valid held", rsp1_valid, 1);
                check("rsp1 stable", {rsp1_result, rsp1_flags}, hold1);
            end
            hold0_v = rsp0_valid && !rsp0_ready;
            hold1_v = rsp1_valid && !rsp1_ready;
            hold0   = {rsp0_result, rsp0_flags};
            hold1   = {rsp1_result, rsp1_flags};
            if (rsp0_valid) begin
                if (q0.size() == 0) check("rsp0 unexpected", rsp0_valid, 0);
                else begin
                    check("rsp0 data", {rsp0_result, rsp0_flags}, q0[0]);
                    check("rsp1 quiet", rsp1_valid, 0);
                    if (rsp0_ready) begin
                        check("done0_cnt", done0_cnt, mcnt0);
                        mcnt0 = (mcnt0 + 1) % (1 << CW);
                        void'(q0.pop_front());
                        outst = 1'b0;
                    end
                end
            end
            if (rsp1_valid) begin
                if (q1.size() == 0) check("rsp1 unexpected", rsp1_valid, 0);
                else begin
                    check("rsp1 data", {rsp1_result, rsp1_flags}, q1[0]);
                    check("rsp0 quiet", rsp0_valid, 0);
                    if (rsp1_ready) begin
                        check("done1_cnt", done1_cnt, mcnt1);
                        mcnt1 = (mcnt1 + 1) % (1 << CW);
                        void'(q1.pop_front());
                        outst = 1'b0;
                    end
                end
            end
            if (req0_valid && req0_ready) begin
                q0.push_back(alu_ref(req0_sel, req0_a, req0_b));
                mpref = 1'b1; outst = 1'b1; glog.push_back(0);
            end else if (req1_valid && req1_ready) begin
                q1.push_back(alu_ref(req1_sel, req1_a, req1_b));
                mpref = 1'b0; outst = 1'b1; glog.push_back(1);
            end
        end
    end

    // Called just after a rising edge; returns just after the rising edge that consumes the result.
    task automatic do_op(input int n, input logic [3:0] sel, input logic [DW-1:0] a,
                         input logic [DW-1:0] b, output int lat);
        logic seen;
        seen = 1'b0;
        lat  = 0;
        if (n == 0) begin req0_valid = 1; req0_sel = sel; req0_a = a; req0_b = b; end
        else        begin req1_valid = 1; req1_sel = sel; req1_a = a; req1_b = b; end
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = (n == 0) ? req0_ready : req1_ready;
        end
        @(posedge clk); #1;
        if (n == 0) req0_valid = 0; else req1_valid = 0;
        check("accept", seen, 1);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            lat++;
            seen = (n == 0) ? rsp0_valid : rsp1_valid;
        end
        check("rsp seen", seen, 1);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL global timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        int            lat, n0, n1;
        rsp_t          e;
        logic [CW-1:0] d0b, d1b, diff;
        req0_valid = 0; req1_valid = 0; req0_sel = 0; req1_sel = 0;
        req0_a = 0; req0_b = 0; req1_a = 0; req1_b = 0;
        rsp0_ready = 0; rsp1_ready = 0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset rsp0_valid", rsp0_valid, 0);
        check("reset rsp1_valid", rsp1_valid, 0);
        check("reset rsp0", {rsp0_result, rsp0_flags}, 0);
        check("reset rsp1", {rsp1_result, rsp1_flags}, 0);
        check("reset alu drive", {ALU_SEL, A, B}, 0);
        check("reset counters", {done0_cnt, done1_cnt}, 0);
        check("reset busy", busy, 0);
        @(posedge clk); #1;
        rst_n = 1; rsp0_ready = 1; rsp1_ready = 1;

        // First accept on the first edge after reset release, two-edge latency.
        do_op(0, 4'd0, 5, 7, lat);
        check("latency", lat, 2);
        check("add result", rsp0_result, 12);
        check("add flags", rsp0_flags, 0);
        check("done0 after one", done0_cnt, 1);

        do_op(0, 4'd1, 3, 3, lat);
        check("sub zero result", rsp0_result, 0);
        check("sub zero flag", rsp0_flags[3], 1);
        do_op(0, 4'd1, 5, 3, lat);
        check("sub neg result", rsp0_result, 32'hFFFF_FFFE);
        check("sub neg flag", rsp0_flags[2], 1);

        // Stalled response on requester 1 while requester 0 waits.
        rsp1_ready = 0;
        e = alu_ref(4'd3, 32'h1234_0000, 32'h0000_5678);
        do_op(1, 4'd3, 32'h1234_0000, 32'h0000_5678, lat);
        req0_valid = 1; req0_sel = 4'd4; req0_a = 32'hAAAA_5555; req0_b = 32'h0F0F_0F0F;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("stall rsp1_valid", rsp1_valid, 1);
            check("stall rsp1 data", {rsp1_result, rsp1_flags}, e);
            check("stall req0_ready", req0_ready, 0);
            check("stall busy", busy, 1);
        end
        @(posedge clk); #1;
        rsp1_ready = 1;
        lat = 0;
        for (int i = 0; i < 20 && lat == 0; i++) begin
            @(negedge clk);
            lat = req0_ready ? 1 : 0;
        end
        check("req0 served after stall", lat, 1);
        @(posedge clk); #1;
        req0_valid = 0;
        repeat (4) @(posedge clk);
        #1;

        // Continuous contention: grants must alternate.
        d0b = done0_cnt; d1b = done1_cnt;
        glog.delete();
        req0_valid = 1; req0_sel = 4'd0; req0_a = $urandom; req0_b = $urandom;
        req1_valid = 1; req1_sel = 4'd2; req1_a = $urandom; req1_b = $urandom;
        for (int i = 0; i < 100 && glog.size() < 8; i++) @(posedge clk);
        #1;
        req0_valid = 0; req1_valid = 0;
        repeat (5) @(posedge clk);
        #1;
        check("grant count", glog.size() >= 8, 1);
        n0 = 0; n1 = 0;
        foreach (glog[i]) begin
            if (glog[i] == 0) n0++; else n1++;
            if (i > 0) check("grants alternate", glog[i], 1 - glog[i-1]);
        end
        diff = done0_cnt - d0b;
        check("done0 delta", diff, CW'(n0));
        diff = done1_cnt - d1b;
        check("done1 delta", diff, CW'(n1));

        // Reset while the operation is in EXEC.
        req0_valid = 1; req0_sel = 4'd0; req0_a = 100; req0_b = 23;
        @(negedge clk);
        @(posedge clk); #1;
        req0_valid = 0;
        rst_n = 0;
        #2;
        check("mid reset rsp valid", {rsp0_valid, rsp1_valid}, 0);
        check("mid reset busy", busy, 0);
        check("mid reset counters", {done0_cnt, done1_cnt}, 0);
        check("mid reset alu drive", {ALU_SEL, A, B}, 0);
        @(posedge clk); #1;
        rst_n = 1;
        repeat (3) @(posedge clk);
        #1;
        check("no rsp after reset", {rsp0_valid, rsp1_valid, done0_cnt}, 0);
        do_op(0, 4'd0, 100, 23, lat);
        check("post reset result", rsp0_result, 123);
        check("post reset done0", done0_cnt, 1);

        // Randomized traffic, including input churn while busy.
        for (int c = 0; c < 400; c++) begin
            @(posedge clk); #1;
            req0_valid = 1'($urandom_range(0, 1));
            req1_valid = 1'($urandom_range(0, 1));
            req0_sel = 4'($urandom_range(0, 5)); req0_a = $urandom; req0_b = $urandom;
            req1_sel = 4'($urandom_range(0, 5)); req1_a = $urandom; req1_b = $urandom;
            rsp0_ready = ($urandom_range(0, 3) != 0);
            rsp1_ready = ($urandom_range(0, 3) != 0);
        end
        req0_valid = 0; req1_valid = 0; rsp0_ready = 1; rsp1_ready = 1;
        repeat (6) @(posedge clk);
        #1;

        // Counter wrap on a CW-bit counter.
        for (int i = 0; i < 20 && mcnt0 != (1 << CW) - 1; i++)
            do_op(0, 4'd2, $urandom, $urandom, lat);
        check("done0 at max", done0_cnt, (1 << CW) - 1);
        do_op(0, 4'd0, 1, 1, lat);
        check("done0 wraps", done0_cnt, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
